// File: rtl/fifo_level_if.sv
// Handshake and status bundle for fifo_level.
// The master side drives requests; the FIFO sits on the slave side.
interface fifo_level_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] din;
  logic                  write;
  logic                  read;
  logic                  flush;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din,
    output write,
    output read,
    output flush,
    output clr_err,
    input  dout,
    input  dout_valid,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  level,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  din,
    input  write,
    input  read,
    input  flush,
    input  clr_err,
    output dout,
    output dout_valid,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output level,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/fifo_level.sv
// Arbitrary-depth synchronous FIFO with fill level, almost flags,
// sticky error flags, flush and selectable FWFT/registered read.
module fifo_level #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input logic         clk,
  input logic         rst_n,
  fifo_level_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  ptr_t                  r_head;
  ptr_t                  r_tail;
  logic [LW-1:0]         r_level;
  logic                  r_ovf;
  logic                  r_unf;

  logic          w_empty;
  logic          w_full;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic          w_ovf_set;
  logic          w_unf_set;
  ptr_t          w_head_inc;
  ptr_t          w_tail_inc;
  logic [LW-1:0] w_level_nxt;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));

  // Flush masks both requests so neither moves state nor flags errors.
  assign w_rd_acc = bus.read && !w_empty && !bus.flush;
  assign w_wr_acc = bus.write && (!w_full || w_rd_acc)
                    && !bus.flush;

  assign w_ovf_set = bus.write && !w_wr_acc && !bus.flush;
  assign w_unf_set = bus.read && w_empty && !bus.flush;

  // Explicit wrap keeps non-power-of-2 depths correct.
  assign w_head_inc = (r_head == PW'(DEPTH - 1))
                      ? '0 : r_head + 1'b1;
  assign w_tail_inc = (r_tail == PW'(DEPTH - 1))
                      ? '0 : r_tail + 1'b1;

  always_comb begin
    w_level_nxt = r_level;
    unique case (1'b1)
      (w_wr_acc && !w_rd_acc): w_level_nxt = r_level + 1'b1;
      (w_rd_acc && !w_wr_acc): w_level_nxt = r_level - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_acc) r_head <= w_head_inc;
      if (w_rd_acc) r_tail <= w_tail_inc;
      r_level <= w_level_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (bus.clr_err) r_ovf <= 1'b0;
      if (w_unf_set)        r_unf <= 1'b1;
      else if (bus.clr_err) r_unf <= 1'b0;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_head] <= bus.din;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.dout       = r_mem[r_tail];
    assign bus.dout_valid = !w_empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dv;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dout <= '0;
        r_dv   <= 1'b0;
      end else if (w_rd_acc) begin
        r_dout <= r_mem[r_tail];
        r_dv   <= 1'b1;
      end else begin
        r_dv   <= 1'b0;
      end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dv;
  end

  assign bus.level        = r_level;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_level >= LW'(AFULL_THRESH));
  assign bus.almost_empty = (r_level <= LW'(AEMPTY_THRESH));
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;
endmodule

// File: doc/fifo_level.md
Name: fifo_level

Overview:
- Parametrised successor to the team's small synchronous FIFO.
- Adds arbitrary (non-power-of-2) depth, a selectable read mode (first-word-fall-through or registered), a fill-level output and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags and a synchronous flush.
- Used as the elastic buffer between I2C/sensor-control command producers and their sequencers.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- DEPTH, 16, number of entries; any value >= 2 (power of 2 not required).
- FWFT, 1, 1 = first-word-fall-through, 0 = registered read with 1-cycle latency.
- AFULL_THRESH, DEPTH-2, almost_full asserted when level >= this; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserted when level <= this; legal range 0..DEPTH-1.
- LW (localparam), $clog2(DEPTH+1), width of level.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  DATA_WIDTH  write data.
- write  in  1  write request.
- read  in  1  read/pop request.
- flush  in  1  synchronous discard of all contents.
- clr_err  in  1  synchronous clear of overflow/underflow.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  FWFT=1: equals !empty. FWFT=0: pulses 1 cycle after an accepted read.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AFULL_THRESH.
- almost_empty  out  1  level <= AEMPTY_THRESH.
- level  out  LW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release):
  - head, tail and level are 0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (since AFULL_THRESH >= 1).
  - overflow=0, underflow=0, dout_valid=0, registered dout=0.
  - Memory is not reset; it is initialised to 0 at configuration only.
  - Reset mid-transfer discards all contents; the first write after release lands in entry 0.
- Acceptance:
  - rd_acc = read && !empty.
  - wr_acc = write && (!full || rd_acc). A write on a full FIFO is accepted only if a read pops in the same cycle.
- Level update: level += wr_acc − rd_acc.
  - Both accepted: level unchanged, both pointers advance.
  - Write and read on empty: write accepted, read rejected.
- Pointers: wrap from DEPTH-1 to 0 by explicit compare, not modulo 2^n.
- Memory: written at head on wr_acc. Read and write of the same address in one cycle cannot occur except in the full+read+write case, where the read takes the old word.
- FWFT=1: dout = mem[tail] combinationally; new data is visible the cycle after the write; rd_acc pops.
- FWFT=0:
  - On rd_acc, dout <= mem[tail] and dout_valid <= 1 on the next edge.
  - Otherwise dout holds its value and dout_valid <= 0.
- Status flags: full, empty, almost_full and almost_empty decode combinationally from the registered level. They change only on clock edges.
- Errors:
  - overflow sets on write && !wr_acc.
  - underflow sets on read && empty.
  - Both hold until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, set wins.
- Flush:
  - Takes priority over read and write in that cycle; both are ignored, and no error flags set from them.
  - Next cycle: head=tail=0, level=0, dout_valid=0.
  - Registered dout holds its value; error flags are unaffected.

Test Plan:
- Config DEPTH=5, AFULL_THRESH=3, AEMPTY_THRESH=1, FWFT=1. Write 0xA0..0xA4 on consecutive cycles -> level 1..5; almost_empty drops at level 2; almost_full rises at level 3; full at 5. Then one more write of 0xA5 -> overflow=1, level stays 5. Read out -> 0xA0..0xA4 in order, empty=1 after the 5th.
- Same config, full: read and write 0xB0 together -> level stays 5, dout advances to the next word, no overflow. Drain -> 0xB0 is the last word out.
- Empty FIFO: read and write 0xC0 together -> underflow=1, level=1, dout=0xC0 the next cycle. Assert clr_err -> underflow=0 the next cycle.
- FWFT=0: write 0x11 then 0x22, then read on 2 consecutive cycles -> dout=0x11 with dout_valid=1 one cycle after the first read, then dout=0x22. dout_valid=0 on the following cycle; dout holds 0x22.
- Wrap: 13 interleaved write/read bursts with random gaps (pointers wrap at least twice) -> scoreboard matches every word and level equals the model count each cycle. Assert flush with level=3 -> level=0, empty=1 the next cycle; the next write/read returns the new word.
- Pull rst_n low asynchronously mid-burst at level=4 -> all outputs go to reset values without a clock edge. After release, a write of 0xD0 then a read returns 0xD0.
